// File: rtl/aes_128_pkg.sv
// Shared constants, FSM encoding and round-constant lookup for the AES-128 key schedule.
package aes_128_pkg;

  localparam int NUM_ROUNDS    = 10;
  localparam int KEYRAM_ADDR_W = 5;
  localparam int KEYRAM_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    WR_HI,
    WR_LO,
    CALC
  } state_t;

  localparam logic [0:NUM_ROUNDS-1][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // idx is the round just written; the next round key uses RCON[idx].
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    if (idx < 4'(NUM_ROUNDS)) return RCON[idx];
    return 8'h00;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, table stored as one packed constant (entry 0x00 at the MSB).
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] subst
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base;

  assign base  = {~data, 3'b000};
  assign subst = SBOX[base +: 8];

endmodule

// File: rtl/aes_128_key_expand.sv
// Iterative AES-128 key expansion feeding the round-key RAM, one 64-bit half per write.
// Define AES_KEY_EXPAND_REVERSE_EN to store round 10 at the base address (decryption order).
module aes_128_key_expand
  import aes_128_pkg::*;
#(
  parameter int ADDR_BASE = 0
) (
  input  logic                     clk,
  input  logic                     kill,
  input  logic                     start,
  input  logic [127:0]             key_in,
  output logic                     en_wr,
  output logic [KEYRAM_ADDR_W-1:0] addr_wr,
  output logic [KEYRAM_DATA_W-1:0] key_round_wr,
  output logic                     busy,
  output logic                     done
);

  state_t                     state_reg, state_next;
  logic [3:0]                 round_reg, round_next;
  logic [127:0]               key_reg, key_next;
  logic                       en_wr_reg, en_wr_next;
  logic [KEYRAM_ADDR_W-1:0]   addr_reg, addr_next;
  logic [KEYRAM_DATA_W-1:0]   data_reg, data_next;
  logic                       busy_reg;
  logic                       done_reg;
  logic                       last_reg, last_next;

  logic [KEYRAM_ADDR_W-1:0]   slot;
  logic [KEYRAM_ADDR_W-1:0]   hi_addr;
  logic [31:0]                w0, w1, w2, w3;
  logic [31:0]                rot, sub, t;
  logic [31:0]                n0, n1, n2, n3;

`ifdef AES_KEY_EXPAND_REVERSE_EN
  assign slot = KEYRAM_ADDR_W'(NUM_ROUNDS) - {1'b0, round_reg};
`else
  assign slot = {1'b0, round_reg};
`endif
  assign hi_addr = KEYRAM_ADDR_W'(ADDR_BASE) + {slot[KEYRAM_ADDR_W-2:0], 1'b0};

  assign {w0, w1, w2, w3} = key_reg;
  assign rot = {w3[23:0], w3[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .data  (rot[gi*8 +: 8]),
        .subst (sub[gi*8 +: 8])
      );
    end
  endgenerate

  assign t  = sub ^ {rcon(round_reg), 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_comb begin
    state_next = state_reg;
    round_next = round_reg;
    key_next   = key_reg;
    en_wr_next = 1'b0;
    addr_next  = '0;
    data_next  = '0;
    last_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          key_next   = key_in;
          round_next = 4'd0;
          state_next = WR_HI;
        end
      end
      WR_HI: begin
        if (round_reg > 4'(NUM_ROUNDS)) begin
          state_next = IDLE;
        end else begin
          en_wr_next = 1'b1;
          addr_next  = hi_addr;
          data_next  = key_reg[127:64];
          state_next = WR_LO;
        end
      end
      WR_LO: begin
        if (round_reg > 4'(NUM_ROUNDS)) begin
          state_next = IDLE;
        end else begin
          en_wr_next = 1'b1;
          addr_next  = hi_addr + KEYRAM_ADDR_W'(1);
          data_next  = key_reg[63:0];
          if (round_reg == 4'(NUM_ROUNDS)) begin
            last_next  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = CALC;
          end
        end
      end
      CALC: begin
        // Unreachable round values end the run silently rather than wrapping.
        if (round_reg >= 4'(NUM_ROUNDS)) begin
          state_next = IDLE;
        end else begin
          key_next   = {n0, n1, n2, n3};
          round_next = round_reg + 4'd1;
          state_next = WR_HI;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are a registered image of the decode, so done lands one cycle after the last write.
  always_ff @(posedge clk) begin
    if (kill) begin
      state_reg <= IDLE;
      round_reg <= 4'd0;
      key_reg   <= '0;
      en_wr_reg <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      round_reg <= round_next;
      key_reg   <= key_next;
      en_wr_reg <= en_wr_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      busy_reg  <= (state_reg != IDLE);
      last_reg  <= last_next;
      done_reg  <= last_reg;
    end
  end

  assign en_wr        = en_wr_reg;
  assign addr_wr      = addr_reg;
  assign key_round_wr = data_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_aes_128_key_expand.sv
// Scoreboard bench for aes_128_key_expand: a GF(2^8)-arithmetic reference schedule predicts every write.
module tb_aes_128_key_expand;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         kill;
  logic         start;
  logic [127:0] key_in;
  logic         en_wr;
  logic [4:0]   addr_wr;
  logic [63:0]  key_round_wr;
  logic         busy;
  logic         done;

  aes_128_key_expand #(.ADDR_BASE(0)) dut (
    .clk          (clk),
    .kill         (kill),
    .start        (start),
    .key_in       (key_in),
    .en_wr        (en_wr),
    .addr_wr      (addr_wr),
    .key_round_wr (key_round_wr),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t          sb[$];
  int           checks = 0;
  int           passed = 0;
  int           nwr = 0;
  bit           mon_en = 1'b0;
  logic [63:0]  seen [32];
  logic [127:0] model_rk [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the affine transform.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] b;
    b = 8'h01;
    for (int i = 0; i < 254; i++) b = gmul(b, x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  task automatic model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    {w[0], w[1], w[2], w[3]} = k;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [4:0] exp_addr(input int r, input int lo);
`ifdef AES_KEY_EXPAND_REVERSE_EN
    return 5'(2 * (10 - r) + lo);
`else
    return 5'(2 * r + lo);
`endif
  endfunction

  // Drives a start pulse and queues the writes expected before relative cycle 'limit'.
  // Returns at the negedge of relative cycle 0 with t0 = absolute cycle of the start edge.
  task automatic launch(input logic [127:0] k, input int limit, output int t0);
    @(negedge clk);
    model(k);
    for (int i = 0; i < 32; i++) seen[i] = 64'h0;
    nwr = 0;
    start  = 1'b1;
    key_in = k;
    t0 = cyc + 1;
    for (int r = 0; r <= 10; r++) begin
      if (3*r + 1 < limit) sb.push_back('{t0 + 3*r + 1, exp_addr(r, 0), model_rk[r][127:64]});
      if (3*r + 2 < limit) sb.push_back('{t0 + 3*r + 2, exp_addr(r, 1), model_rk[r][63:0]});
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (mon_en) begin
      checks++;
      if (en_wr === 1'b1) begin
        nwr++;
        $display("write cyc=%0d addr=%0d data=%h", cyc, addr_wr, key_round_wr);
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected_write cyc=%0d addr=%0d data=%h, required no write", cyc, addr_wr, key_round_wr);
        end else begin
          e = sb.pop_front();
          if (e.cyc !== cyc || e.addr !== addr_wr || e.data !== key_round_wr)
            $display("FAIL sb_write got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                     cyc, addr_wr, key_round_wr, e.cyc, e.addr, e.data);
          else passed++;
        end
        seen[addr_wr] = key_round_wr;
      end else begin
        if (addr_wr !== 5'd0 || key_round_wr !== 64'h0)
          $display("FAIL idle_bus cyc=%0d got addr=%0d data=%h, required 0/0", cyc, addr_wr, key_round_wr);
        else passed++;
      end
    end
  end

  task automatic test_reset();
    kill = 1'b1; start = 1'b0; key_in = '0;
    repeat (3) @(negedge clk);
    checks++; if (en_wr !== 1'b0) $display("FAIL reset_en_wr got %b required 0", en_wr); else passed++;
    checks++; if (addr_wr !== 5'd0) $display("FAIL reset_addr got %0d required 0", addr_wr); else passed++;
    checks++; if (key_round_wr !== 64'h0) $display("FAIL reset_data got %h required 0", key_round_wr); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b required 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b required 0", done); else passed++;
    mon_en = 1'b1;
    // start alongside kill must be dropped
    start = 1'b1; key_in = FIPS_KEY;
    @(negedge clk);
    kill = 1'b0; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (busy !== 1'b0 || en_wr !== 1'b0)
        $display("FAIL kill_beats_start cycle %0d got busy=%b en_wr=%b required 0/0", i, busy, en_wr);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_fips();
    int t0;
    launch(FIPS_KEY, 100, t0);
    for (int rel = 0; rel <= 35; rel++) begin
      checks++;
      if (busy !== (rel >= 1 && rel <= 32)) $display("FAIL fips_busy rel=%0d got %b", rel, busy); else passed++;
      checks++;
      if (done !== (rel == 33)) $display("FAIL fips_done rel=%0d got %b", rel, done); else passed++;
      checks++;
      if (en_wr !== (rel >= 1 && rel <= 32 && rel % 3 != 0)) $display("FAIL fips_en_wr rel=%0d got %b", rel, en_wr); else passed++;
      @(negedge clk);
    end
    checks++; if (nwr !== 22) $display("FAIL fips_write_count got %0d required 22", nwr); else passed++;
    checks++; if (sb.size() !== 0) $display("FAIL fips_sb_left got %0d required 0", sb.size()); else passed++;
    checks++; if (seen[exp_addr(0,0)] !== 64'h2b7e151628aed2a6) $display("FAIL fips_r0_hi got %h required 2b7e151628aed2a6", seen[exp_addr(0,0)]); else passed++;
    checks++; if (seen[exp_addr(0,1)] !== 64'habf7158809cf4f3c) $display("FAIL fips_r0_lo got %h required abf7158809cf4f3c", seen[exp_addr(0,1)]); else passed++;
    checks++; if (seen[exp_addr(1,0)] !== 64'ha0fafe1788542cb1) $display("FAIL fips_r1_hi got %h required a0fafe1788542cb1", seen[exp_addr(1,0)]); else passed++;
    checks++; if (seen[exp_addr(1,1)] !== 64'h23a339392a6c7605) $display("FAIL fips_r1_lo got %h required 23a339392a6c7605", seen[exp_addr(1,1)]); else passed++;
    checks++; if (seen[exp_addr(10,0)] !== 64'hd014f9a8c9ee2589) $display("FAIL fips_r10_hi got %h required d014f9a8c9ee2589", seen[exp_addr(10,0)]); else passed++;
    checks++; if (seen[exp_addr(10,1)] !== 64'he13f0cc8b6630ca6) $display("FAIL fips_r10_lo got %h required e13f0cc8b6630ca6", seen[exp_addr(10,1)]); else passed++;
  endtask

  task automatic test_restart_ignored();
    int t0;
    launch(FIPS_KEY, 100, t0);
    for (int rel = 0; rel <= 35; rel++) begin
      if (rel == 9)  begin start = 1'b1; key_in = '1; end
      if (rel == 10) start = 1'b0;
      checks++;
      if (done !== (rel == 33)) $display("FAIL restart_done rel=%0d got %b", rel, done); else passed++;
      @(negedge clk);
    end
    checks++; if (nwr !== 22) $display("FAIL restart_write_count got %0d required 22", nwr); else passed++;
    checks++; if (sb.size() !== 0) $display("FAIL restart_sb_left got %0d required 0", sb.size()); else passed++;
    checks++; if (seen[exp_addr(10,1)] !== 64'he13f0cc8b6630ca6) $display("FAIL restart_r10_lo got %h required e13f0cc8b6630ca6", seen[exp_addr(10,1)]); else passed++;
  endtask

  task automatic test_kill();
    int t0;
    launch(FIPS_KEY, 12, t0);
    for (int rel = 0; rel <= 40; rel++) begin
      if (rel == 11) kill = 1'b1;
      if (rel == 12) kill = 1'b0;
      if (rel >= 13) begin
        checks++;
        if (en_wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
          $display("FAIL kill_quiet rel=%0d got en_wr=%b busy=%b done=%b required 0/0/0", rel, en_wr, busy, done);
        else passed++;
      end
      @(negedge clk);
    end
    checks++; if (nwr !== 8) $display("FAIL kill_write_count got %0d required 8", nwr); else passed++;
    checks++; if (sb.size() !== 0) $display("FAIL kill_sb_left got %0d required 0", sb.size()); else passed++;
  endtask

  task automatic test_zero_key();
    int t0;
    launch(128'h0, 100, t0);
    for (int rel = 0; rel <= 35; rel++) begin
      checks++;
      if (done !== (rel == 33)) $display("FAIL zero_done rel=%0d got %b", rel, done); else passed++;
      @(negedge clk);
    end
    checks++; if (seen[exp_addr(1,0)] !== 64'h6263636362636363) $display("FAIL zero_r1_hi got %h required 6263636362636363", seen[exp_addr(1,0)]); else passed++;
    checks++; if (seen[exp_addr(1,1)] !== 64'h6263636362636363) $display("FAIL zero_r1_lo got %h required 6263636362636363", seen[exp_addr(1,1)]); else passed++;
    checks++; if (seen[exp_addr(10,0)] !== 64'hb4ef5bcb3e92e211) $display("FAIL zero_r10_hi got %h required b4ef5bcb3e92e211", seen[exp_addr(10,0)]); else passed++;
    checks++; if (seen[exp_addr(10,1)] !== 64'h23e951cf6f8f188e) $display("FAIL zero_r10_lo got %h required 23e951cf6f8f188e", seen[exp_addr(10,1)]); else passed++;
    checks++; if (sb.size() !== 0) $display("FAIL zero_sb_left got %0d required 0", sb.size()); else passed++;
  endtask

  initial begin
    kill = 1'b1; start = 1'b0; key_in = '0;
    test_reset();
    test_fips();
    test_restart_ignored();
    test_kill();
    test_fips();
    test_zero_key();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cyc=%0d required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
